// File: rtl/vga_ctrl.sv
// vga_ctrl: VGA 640x480@60 timing generator with registered hs/vs/video_on/colour stage.
// Build macro VGA_COLOR_BARS_EN replaces pix_rgb with eight 80-pixel vertical colour bars.
module vga_ctrl #(
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] pix_rgb,
   output logic [9:0]  col,
   output logic [9:0]  row,
   output logic        pix_tick,
   output logic        frame_tick,
   output logic        video_on,
   output logic        hs,
   output logic        vs,
   output logic [3:0]  r,
   output logic [3:0]  g,
   output logic [3:0]  b
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS = 10'(V_ACTIVE);
   localparam logic [9:0] HS_LO = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_HI = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_LO = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_HI = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [DW-1:0] div;
   logic          tick;
   logic          h_last;
   logic          v_last;
   logic          visible;
   logic [11:0]   rgb;

   assign tick       = div == DIV_LAST;
   assign h_last     = col == H_LAST;
   assign v_last     = row == V_LAST;
   assign visible    = col < H_VIS && row < V_VIS;
   assign pix_tick   = tick && !rst;
   assign frame_tick = pix_tick && h_last && v_last;

`ifdef VGA_COLOR_BARS_EN
   logic [9:0] bar;
   logic       unused_bits;
   assign bar         = col / 10'd80;
   assign rgb         = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
   assign unused_bits = ^{pix_rgb, bar[9:3]};
`else
   assign rgb = pix_rgb;
`endif

   // Pixel divider, scan counters and the output stage that lags col/row by one pixel
   always_ff @(posedge clk) begin
      if (rst) begin
         div      <= '0;
         col      <= '0;
         row      <= '0;
         video_on <= 1'b0;
         hs       <= 1'b1;
         vs       <= 1'b1;
         {r, g, b} <= 12'h000;
      end else begin
         div <= tick ? '0 : div + 1'b1;
         if (tick) begin
            video_on  <= visible;
            hs        <= !(col >= HS_LO && col <= HS_HI);
            vs        <= !(row >= VS_LO && row <= VS_HI);
            {r, g, b} <= visible ? rgb : 12'h000;
            col       <= h_last ? '0 : col + 1'b1;
            if (h_last)
               row <= v_last ? '0 : row + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_vga_ctrl.sv
// tb_vga_ctrl: scoreboard bench for vga_ctrl; one reduced-timing instance covers whole
// frames and frame_tick, one default-parameter instance covers the 640x480 line timing.
module tb_vga_ctrl;
   typedef struct packed {
      logic [9:0]  col;
      logic [9:0]  row;
      logic        vid;
      logic        hs;
      logic        vs;
      logic [11:0] rgb;
   } exp_t;

   logic clk = 1'b0;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   for (genvar i = 0; i < 2; i++) begin : g
      localparam int D   = i == 0 ? 3 : 4;
      localparam int HA  = i == 0 ? 40 : 640;
      localparam int HFP = i == 0 ? 4 : 16;
      localparam int HSW = i == 0 ? 6 : 96;
      localparam int HBP = i == 0 ? 4 : 48;
      localparam int VA  = i == 0 ? 8 : 480;
      localparam int VFP = i == 0 ? 2 : 10;
      localparam int VSW = i == 0 ? 2 : 2;
      localparam int VBP = i == 0 ? 3 : 33;
      localparam int HT  = HA + HFP + HSW + HBP;
      localparam int VT  = VA + VFP + VSW + VBP;
      localparam int RA  = i == 0 ? 5001 : 9000;
      localparam int RB  = i == 0 ? 7777 : 50000;

      logic        rst = 1'b1;
      logic [11:0] pix_rgb = 12'h000;
      logic [9:0]  col, row;
      logic        pix_tick, frame_tick, video_on, hs, vs;
      logic [3:0]  r, g, b;
      exp_t        q[$];

      if (i == 0) begin : p
         vga_ctrl #(.CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)) u (
            .clk(clk), .rst(rst), .pix_rgb(pix_rgb), .col(col), .row(row),
            .pix_tick(pix_tick), .frame_tick(frame_tick), .video_on(video_on),
            .hs(hs), .vs(vs), .r(r), .g(g), .b(b));
      end else begin : p
         vga_ctrl u (
            .clk(clk), .rst(rst), .pix_rgb(pix_rgb), .col(col), .row(row),
            .pix_tick(pix_tick), .frame_tick(frame_tick), .video_on(video_on),
            .hs(hs), .vs(vs), .r(r), .g(g), .b(b));
      end

      // Stimulus and reference model: n counts pixels since reset, c counts clocks since reset
      initial begin
         int n, c, cyc, x, y;
         bit tk;
         exp_t e;
`ifdef VGA_COLOR_BARS_EN
         logic [11:0] lut [8] = '{12'h000, 12'h00F, 12'h0F0, 12'h0FF,
                                  12'hF00, 12'hF0F, 12'hFF0, 12'hFFF};
`endif
         n = 0;
         c = 0;
         cyc = 0;
         forever begin
            @(negedge clk);
            rst = cyc < 3 || cyc == RA || cyc == RB || cyc == RB + 1;
            x = n % HT;
            y = (n / HT) % VT;
            pix_rgb = (x >= HA || y >= VA) ? 12'hFFF : 12'($urandom);
            #1;
            tk = !rst && (c % D == D - 1);
            if (cyc > 0) begin
               chk($sformatf("i%0d col", i), int'(col), x);
               chk($sformatf("i%0d row", i), int'(row), y);
            end
            chk($sformatf("i%0d pix_tick", i), int'(pix_tick), int'(tk));
            chk($sformatf("i%0d frame_tick", i), int'(frame_tick),
                int'(tk && (n % (HT * VT) == HT * VT - 1)));
            if (rst) begin
               e = '0;
               e.hs = 1'b1;
               e.vs = 1'b1;
               q.push_back(e);
               n = 0;
               c = 0;
            end else begin
               if (tk) begin
                  e.col = 10'((n + 1) % HT);
                  e.row = 10'(((n + 1) / HT) % VT);
                  e.vid = x < HA && y < VA;
                  e.hs  = !(x >= HA + HFP && x < HA + HFP + HSW);
                  e.vs  = !(y >= VA + VFP && y < VA + VFP + VSW);
`ifdef VGA_COLOR_BARS_EN
                  e.rgb = e.vid ? lut[x / 80] : 12'h000;
`else
                  e.rgb = e.vid ? pix_rgb : 12'h000;
`endif
                  q.push_back(e);
                  n++;
               end
               c++;
            end
            cyc++;
         end
      end

      // Monitor: after every reset or tick edge the DUT presents a new output word
      initial begin
         bit pend;
         exp_t e;
         pend = 1'b0;
         forever begin
            @(negedge clk);
            if (pend) begin
               if (q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL i%0d out at %0t: output update with no expected entry", i, $time);
               end else begin
                  e = q.pop_front();
                  chk($sformatf("i%0d out_col", i), int'(col), int'(e.col));
                  chk($sformatf("i%0d out_row", i), int'(row), int'(e.row));
                  chk($sformatf("i%0d video_on", i), int'(video_on), int'(e.vid));
                  chk($sformatf("i%0d hs", i), int'(hs), int'(e.hs));
                  chk($sformatf("i%0d vs", i), int'(vs), int'(e.vs));
                  chk($sformatf("i%0d rgb", i), int'({r, g, b}), int'(e.rgb));
               end
            end
            #1;
            pend = rst || pix_tick;
         end
      end
   end

   initial begin
      repeat (12000) @(posedge clk);
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
